// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-FF sync, per-button debounce, press/release pulses and
// rate-limited move strobes. Define BTN_AUTOREPEAT_EN to build the auto-repeat FSMs.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_level,
    output logic [4:0] btn_press,
    output logic [4:0] btn_release,
    output logic [3:0] move,
    output logic       press_c
);

    localparam int unsigned NBTN    = 5;
    localparam int unsigned NDIR    = 4;
    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Zero-length debounce or repeat intervals are not meaningful configurations.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    end

    logic [NBTN-1:0]            r_sync1;
    logic [NBTN-1:0]            r_sync2;
    logic [NBTN-1:0][DB_W-1:0]  r_db_cnt;
    logic [NBTN-1:0][DB_W-1:0]  w_db_cnt_next;
    logic [NBTN-1:0]            r_level;
    logic [NBTN-1:0]            w_level_next;
    logic [NBTN-1:0]            r_press;
    logic [NBTN-1:0]            w_press_next;
    logic [NBTN-1:0]            r_release;
    logic [NBTN-1:0]            w_release_next;
    logic [NDIR-1:0]            r_move;
    logic [NDIR-1:0]            w_move_next;

    // Synchroniser, debounce counters and registered level/pulse outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_db_cnt  <= '0;
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_move    <= '0;
        end else begin
            r_sync1   <= btn_raw;
            r_sync2   <= r_sync1;
            r_db_cnt  <= w_db_cnt_next;
            r_level   <= w_level_next;
            r_press   <= w_press_next;
            r_release <= w_release_next;
            r_move    <= w_move_next;
        end
    end

    // A level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        w_db_cnt_next  = r_db_cnt;
        w_level_next   = r_level;
        w_press_next   = '0;
        w_release_next = '0;
        for (int i = 0; i < int'(NBTN); i++) begin
            if (r_sync2[i] == r_level[i]) begin
                w_db_cnt_next[i] = '0;
            end else if (r_db_cnt[i] == DB_LAST) begin
                w_db_cnt_next[i]  = '0;
                w_level_next[i]   = ~r_level[i];
                w_press_next[i]   = ~r_level[i];
                w_release_next[i] = r_level[i];
            end else begin
                w_db_cnt_next[i] = r_db_cnt[i] + DB_W'(1);
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

    rpt_state_t                 r_state      [NDIR];
    rpt_state_t                 w_state_next [NDIR];
    logic [NDIR-1:0][RPT_W-1:0] r_rpt_cnt;
    logic [NDIR-1:0][RPT_W-1:0] w_rpt_cnt_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NDIR); i++) begin
                r_state[i] <= ST_IDLE;
            end
            r_rpt_cnt <= '0;
        end else begin
            for (int i = 0; i < int'(NDIR); i++) begin
                r_state[i] <= w_state_next[i];
            end
            r_rpt_cnt <= w_rpt_cnt_next;
        end
    end

    // The upcoming level is used so a release suppresses a repeat due on the same edge.
    always_comb begin
        w_rpt_cnt_next = r_rpt_cnt;
        w_move_next    = '0;
        for (int i = 0; i < int'(NDIR); i++) begin
            w_state_next[i] = r_state[i];
            case (r_state[i])
                ST_IDLE: begin
                    w_rpt_cnt_next[i] = '0;
                    if (w_press_next[i]) begin
                        w_state_next[i] = ST_DELAY;
                        w_move_next[i]  = 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (!w_level_next[i]) begin
                        w_state_next[i]   = ST_IDLE;
                        w_rpt_cnt_next[i] = '0;
                    end else if (r_rpt_cnt[i] == DELAY_LAST) begin
                        w_state_next[i]   = ST_REPEAT;
                        w_rpt_cnt_next[i] = '0;
                        w_move_next[i]    = 1'b1;
                    end else begin
                        w_rpt_cnt_next[i] = r_rpt_cnt[i] + RPT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (!w_level_next[i]) begin
                        w_state_next[i]   = ST_IDLE;
                        w_rpt_cnt_next[i] = '0;
                    end else if (r_rpt_cnt[i] == PERIOD_LAST) begin
                        w_rpt_cnt_next[i] = '0;
                        w_move_next[i]    = 1'b1;
                    end else begin
                        w_rpt_cnt_next[i] = r_rpt_cnt[i] + RPT_W'(1);
                    end
                end
                default: begin
                    w_state_next[i]   = ST_IDLE;
                    w_rpt_cnt_next[i] = '0;
                end
            endcase
        end
    end
`else
    // Without auto-repeat each direction moves once per debounced press.
    always_comb begin
        w_move_next = w_press_next[NDIR-1:0];
    end
`endif

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign move        = r_move;
    assign press_c     = r_press[4];

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: fixed vector table, hand-written multi-cycle sequences,
// and random button activity checked against a run-length reference model.
module tb_btn_conditioner;

    localparam int unsigned DB = 4;
    localparam int unsigned RD = 20;
    localparam int unsigned RP = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_press;
    logic [4:0] btn_release;
    logic [3:0] move;
    logic       press_c;

    int n_checks = 0;
    int n_fail   = 0;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .move       (move),
        .press_c    (press_c)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [4:0] raw;
        logic [4:0] lvl;
        logic [4:0] prs;
        logic [4:0] rel;
        logic [3:0] mv;
    } vec_t;

    vec_t tbl[$];

    // Reference model: a level flips once the 2-cycle-delayed raw input has
    // disagreed with it for DB edges in a row; moves are timed from the press edge.
    logic [4:0] m_lvl, m_prs, m_rel;
    logic [3:0] m_mv;
    int         m_run [5];
    int         m_t   [4];
    int         m_e;
    logic [4:0] m_hist[$];

    task automatic model_reset();
        m_lvl = '0; m_prs = '0; m_rel = '0; m_mv = '0; m_e = 0;
        m_hist.delete();
        for (int i = 0; i < 5; i++) m_run[i] = 0;
        for (int i = 0; i < 4; i++) m_t[i] = 0;
    endtask

    task automatic model_edge(input logic [4:0] raw);
        logic [4:0] s;
        s = (m_hist.size() >= 2) ? m_hist[m_hist.size() - 2] : 5'h00;
        m_hist.push_back(raw);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
        m_e++;
        m_prs = '0;
        m_rel = '0;
        for (int i = 0; i < 5; i++) begin
            if (s[i] != m_lvl[i]) m_run[i]++;
            else                  m_run[i] = 0;
            if (m_run[i] == int'(DB)) begin
                m_lvl[i] = ~m_lvl[i];
                m_run[i] = 0;
                if (m_lvl[i]) m_prs[i] = 1'b1;
                else          m_rel[i] = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            m_mv[i] = 1'b0;
            if (m_prs[i]) begin
                m_t[i]  = m_e;
                m_mv[i] = 1'b1;
            end
`ifdef BTN_AUTOREPEAT_EN
            else if (m_lvl[i] && m_e >= m_t[i] + int'(RD) &&
                     ((m_e - m_t[i] - int'(RD)) % int'(RP)) == 0) begin
                m_mv[i] = 1'b1;
            end
`endif
        end
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    function automatic logic [19:0] dut_vec();
        return {btn_level, btn_press, btn_release, move, press_c};
    endfunction

    // One clock: drive raw, advance the model on the edge, compare #1 later.
    task automatic step(input logic [4:0] raw);
        btn_raw = raw;
        @(posedge clk);
        if (!reset) model_edge(raw);
        #1;
        check("model", m_e, 32'(dut_vec()), 32'({m_lvl, m_prs, m_rel, m_mv, m_prs[4]}));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        step(5'h00);
        reset = 1'b0;
    endtask

    function automatic vec_t mk(input logic rst, input logic [4:0] raw, input logic [4:0] lvl,
                                input logic [4:0] prs, input logic [4:0] rel, input logic [3:0] mv);
        vec_t v;
        v.rst = rst; v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel; v.mv = mv;
        return v;
    endfunction

    initial begin
        logic [9:0] bounce;
        int         rpt_edges[$];
        int         n_rel;
        logic [4:0] cur;
        int         rate;

        reset   = 1'b1;
        btn_raw = 5'h00;
        model_reset();
        #1;
        check("reset_state", 0, 32'(dut_vec()), 32'h0);
        step(5'h00);
        step(5'h00);
        reset = 1'b0;

        // Clean U press held through edge 8, then released.
        for (int e = 1; e <= 15; e++)
            tbl.push_back(mk(e == 1, (e <= 8) ? 5'h01 : 5'h00,
                             (e >= 6 && e <= 13) ? 5'h01 : 5'h00,
                             (e == 6) ? 5'h01 : 5'h00, (e == 14) ? 5'h01 : 5'h00,
                             (e == 6) ? 4'h1 : 4'h0));
        // Bouncing U: 1,1,0,1,1,... accepted only after four synchronised highs.
        bounce = 10'b11_1111_1011;
        for (int e = 1; e <= 10; e++)
            tbl.push_back(mk(e == 1, {4'h0, bounce[e-1]}, (e >= 9) ? 5'h01 : 5'h00,
                             (e == 9) ? 5'h01 : 5'h00, 5'h00, (e == 9) ? 4'h1 : 4'h0));
        // U+L together, C two cycles later.
        for (int e = 1; e <= 10; e++)
            tbl.push_back(mk(e == 1, (e <= 2) ? 5'h05 : 5'h15,
                             (e >= 8) ? 5'h15 : (e >= 6) ? 5'h05 : 5'h00,
                             (e == 6) ? 5'h05 : (e == 8) ? 5'h10 : 5'h00, 5'h00,
                             (e == 6) ? 4'h5 : 4'h0));

        for (int k = 0; k < tbl.size(); k++) begin
            if (tbl[k].rst) do_reset();
            step(tbl[k].raw);
            check("vec", k, 32'(dut_vec()),
                  32'({tbl[k].lvl, tbl[k].prs, tbl[k].rel, tbl[k].mv, tbl[k].prs[4]}));
        end

        // R held for 50 cycles, then released.
`ifdef BTN_AUTOREPEAT_EN
        rpt_edges = '{6, 26, 31, 36, 41, 46, 51};
`else
        rpt_edges = '{6};
`endif
        do_reset();
        n_rel = 0;
        for (int e = 1; e <= 70; e++) begin
            bit exp_mv;
            step((e <= 50) ? 5'h08 : 5'h00);
            exp_mv = 1'b0;
            foreach (rpt_edges[j]) if (rpt_edges[j] == e) exp_mv = 1'b1;
            check("rpt_move3", e, 32'(move[3]), 32'(exp_mv));
            check("rpt_release3", e, 32'(btn_release[3]), 32'(e == 56));
            if (btn_release[3]) n_rel++;
        end
        check("rpt_release_count", 0, 32'(n_rel), 32'd1);

        // Reset asserted mid-repeat with R still held.
        do_reset();
        for (int e = 1; e <= 35; e++) step(5'h08);
        #3;
        reset = 1'b1;
        #1;
        check("rst_async", 0, 32'(dut_vec()), 32'h0);
        model_reset();
        step(5'h08);
        step(5'h08);
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step(5'h08);
            check("rst_repress", e, 32'(btn_press[3]), 32'(e == 6));
        end

        // Random button activity alternating slow and bouncy segments.
        do_reset();
        cur = 5'h00;
        for (int c = 0; c < 1200; c++) begin
            rate = ((c / 150) % 2 == 0) ? 40 : 4;
            for (int b = 0; b < 5; b++)
                if ($urandom_range(rate - 1, 0) == 0) cur[b] = ~cur[b];
            step(cur);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
